fetch_controller: RTL and testbench

Instruction-fetch sequencer for the multi-cycle RISC-V core. It owns the fetch address, drives a single-outstanding request/grant/valid handshake to instruction memory, and presents each fetched word to decode together with its PC. Jump and branch redirects enter through `pc_set_i`/`pc_target_i`, and the block discards any in-flight stale fetch.

---
 rtl/fetch_controller.sv | 190 +++++++++++++++++++
 tb/tb_fetch_controller.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_controller
//  Description : Instruction-fetch sequencer for the multi-cycle RISC-V core.
//                Owns the fetch address, runs a single-outstanding
//                request/grant/rvalid handshake to instruction memory and
//                presents each fetched word to decode with its PC. Jump and
//                branch redirects arrive on pc_set_i/pc_target_i; a response
//                that is in flight when a redirect arrives is discarded.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i           in   1   clock
//    rst_i           in   1   synchronous active-high reset
//    fetch_en_i      in   1   permits new requests (never aborts one)
//    instr_req_o     out  1   memory request (state REQ)
//    instr_addr_o    out  32  request address, word aligned
//    instr_gnt_i     in   1   memory accepted the request
//    instr_rvalid_i  in   1   read data valid
//    instr_rdata_i   in   32  read data
//    instr_valid_o   out  1   instr_o/instr_pc_o valid (state HOLD)
//    instr_o         out  32  fetched instruction word
//    instr_pc_o      out  32  address of instr_o
//    instr_ready_i   in   1   decode consumes the presented instruction
//    pc_set_i        in   1   redirect strobe
//    pc_target_i     in   32  redirect address
//    misalign_o      out  1   pulse: previous redirect target not aligned
// ============================================================================
module fetch_controller #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_en_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        pc_set_i,
    input  logic [31:0] pc_target_i,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [31:0] c_WORD_STEP = 32'd4;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr;
    logic [31:0] w_addr_nxt;
    logic        r_kill;
    logic        w_kill_nxt;
    logic [31:0] r_tgt;
    logic [31:0] w_tgt_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_misalign;
    logic        w_misalign_nxt;

    // Redirect targets are forced onto a word boundary; the dropped low bits
    // only feed the misalignment flag.
    logic [31:0] w_target;
    // Where to go once a transaction (or a dropped one) is finished.
    state_t      w_state_after;

    assign w_target      = {pc_target_i[31:2], 2'b00};
    assign w_state_after = fetch_en_i ? ST_REQ : ST_IDLE;

    // ------------------------------------------------------------------
    // Next-state and datapath decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_kill_nxt     = r_kill;
        w_tgt_nxt      = r_tgt;
        w_instr_nxt    = r_instr;
        w_pc_nxt       = r_pc;
        w_misalign_nxt = pc_set_i & (pc_target_i[1:0] != 2'b00);

        case (r_state)
            ST_IDLE: begin
                // No transaction open: a redirect can move the address directly.
                if (pc_set_i) begin
                    w_addr_nxt = w_target;
                end
                if (fetch_en_i) begin
                    w_state_nxt = ST_REQ;
                end
            end

            ST_REQ: begin
                // The address must stay stable while the request is pending,
                // so a redirect is parked in tgt and the response marked stale.
                if (pc_set_i) begin
                    w_kill_nxt = 1'b1;
                    w_tgt_nxt  = w_target;
                end
                if (instr_gnt_i) begin
                    w_state_nxt = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (instr_rvalid_i) begin
                    if (pc_set_i) begin
                        // Redirect coincides with the response: the fresh
                        // target supersedes anything parked earlier.
                        w_addr_nxt  = w_target;
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = w_state_after;
                    end else if (r_kill) begin
                        w_addr_nxt  = r_tgt;
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = w_state_after;
                    end else begin
                        w_instr_nxt = instr_rdata_i;
                        w_pc_nxt    = r_addr;
                        w_state_nxt = ST_HOLD;
                    end
                end else if (pc_set_i) begin
                    w_kill_nxt = 1'b1;
                    w_tgt_nxt  = w_target;
                end
            end

            ST_HOLD: begin
                // A redirect wins over a simultaneous consume: the held
                // instruction is on the wrong path.
                if (pc_set_i) begin
                    w_addr_nxt  = w_target;
                    w_state_nxt = w_state_after;
                end else if (instr_ready_i) begin
                    w_addr_nxt  = r_addr + c_WORD_STEP;
                    w_state_nxt = w_state_after;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_addr     <= BOOT_ADDR;
            r_kill     <= 1'b0;
            r_tgt      <= 32'h0000_0000;
            r_instr    <= 32'h0000_0000;
            r_pc       <= 32'h0000_0000;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_kill     <= w_kill_nxt;
            r_tgt      <= w_tgt_nxt;
            r_instr    <= w_instr_nxt;
            r_pc       <= w_pc_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    // All outputs come from registers or from the state decode only.
    assign instr_req_o   = (r_state == ST_REQ);
    assign instr_valid_o = (r_state == ST_HOLD);
    assign instr_addr_o  = r_addr;
    assign instr_o       = r_instr;
    assign instr_pc_o    = r_pc;
    assign misalign_o    = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_controller
//  Description : Self-checking bench for fetch_controller. A memory model
//                answers requests with an address-derived word; a scoreboard
//                queue holds the PCs decode is expected to consume.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;

    localparam logic [31:0] C_BOOT = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        ready = 1'b0;
    logic        pc_set = 1'b0;
    logic [31:0] target = 32'h0;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        misalign;

    always #5 clk = ~clk;

    fetch_controller #(.BOOT_ADDR(C_BOOT)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .fetch_en_i     (fetch_en),
        .instr_req_o    (req),
        .instr_addr_o   (addr),
        .instr_gnt_i    (gnt),
        .instr_rvalid_i (rvalid),
        .instr_rdata_i  (rdata),
        .instr_valid_o  (valid),
        .instr_o        (instr),
        .instr_pc_o     (pc),
        .instr_ready_i  (ready),
        .pc_set_i       (pc_set),
        .pc_target_i    (target),
        .misalign_o     (misalign)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] sb[$];     // PCs decode should consume, in order
    logic [31:0] glog[$];   // granted request addresses
    int          gcyc[$];   // cycle index of each grant

    int gnt_dly = 0;
    int rv_dly  = 0;
    int rdy_dly = 0;

    int          ncyc    = 0;
    int          mis_cnt = 0;
    int          vcnt    = 0;
    int          rv_cnt  = 0;
    int          g_cnt   = 0;
    bit          pend    = 1'b0;
    logic [31:0] paddr   = 32'h0;

    logic        p_valid = 1'b0, p_req = 1'b0, p_gnt = 1'b0, p_cons = 1'b0;
    logic        p_pcset = 1'b0, p_rst = 1'b1;
    logic [31:0] p_instr = 32'h0, p_pc = 32'h0, p_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timeout waiting, got none want event", nm);
    endtask

    // Memory model, decode consumer and stall monitors; all on the falling edge.
    always @(negedge clk) begin
        logic        cons;
        logic [31:0] e;
        ncyc++;
        if (!rst && !p_rst) begin
            if (valid && p_valid && !p_cons && !p_pcset) begin
                chk("hold_instr_stable", instr, p_instr);
                chk("hold_pc_stable", pc, p_pc);
            end
            if (req && p_req && !p_gnt)
                chk("req_addr_stable", addr, p_addr);
        end
        if (misalign) mis_cnt++;

        gnt    = 1'b0;
        rvalid = 1'b0;
        if (pend) begin
            if (rv_cnt == 0) begin
                rvalid = 1'b1;
                rdata  = mem_word(paddr);
                pend   = 1'b0;
            end else begin
                rv_cnt--;
            end
        end else if (req && !rst) begin
            if (g_cnt >= gnt_dly) begin
                gnt    = 1'b1;
                pend   = 1'b1;
                paddr  = addr;
                rv_cnt = rv_dly;
                g_cnt  = 0;
                glog.push_back(addr);
                gcyc.push_back(ncyc);
            end else begin
                g_cnt++;
            end
        end

        cons  = 1'b0;
        ready = valid && (sb.size() > 0) && (vcnt >= rdy_dly);
        if (!valid) vcnt = 0;
        else if (!ready) vcnt++;
        if (valid && ready && !pc_set && !rst) begin
            cons = 1'b1;
            vcnt = 0;
            e = sb.pop_front();
            chk("consume_pc", pc, e);
            chk("consume_instr", instr, mem_word(e));
        end

        p_valid = valid; p_req = req; p_gnt = gnt; p_cons = cons;
        p_pcset = pc_set; p_rst = rst;
        p_instr = instr; p_pc = pc; p_addr = addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_quiet();
        bit ok = 1'b0;
        fetch_en = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            if (!req && !pend) ok = 1'b1;
        end
        if (!ok) timeout("wait_quiet");
    endtask

    task automatic wait_sb_empty(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            tick();
            if (sb.size() == 0) ok = 1'b1;
        end
        if (!ok) timeout(nm);
    endtask

    task automatic wait_glog(input int n, input string nm);
        bit ok = (glog.size() >= n);
        for (int i = 0; i < 400 && !ok; i++) begin
            tick();
            if (glog.size() >= n) ok = 1'b1;
        end
        if (!ok) timeout(nm);
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_req"}, {31'h0, req}, 32'h0);
        chk({nm, "_valid"}, {31'h0, valid}, 32'h0);
        chk({nm, "_instr"}, instr, 32'h0);
        chk({nm, "_pc"}, pc, 32'h0);
        chk({nm, "_addr"}, addr, C_BOOT);
        chk({nm, "_misalign"}, {31'h0, misalign}, 32'h0);
    endtask

    typedef struct {
        logic [31:0] start;
        int          gd;
        int          rd;
        int          yd;
        int          n;
        logic [31:0] exp_next;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   base;
        int   first;
        bit   found;

        vecs[0] = '{32'h0000_1000, 0, 0, 0, 3, 32'h0000_100C};
        vecs[1] = '{32'h0000_2000, 2, 0, 5, 3, 32'h0000_200C};
        vecs[2] = '{32'h0000_3004, 1, 2, 1, 2, 32'h0000_300C};
        vecs[3] = '{32'hFFFF_FFFC, 0, 0, 0, 1, 32'h0000_0000};
        vecs[4] = '{32'hFFFF_FFF8, 2, 1, 0, 2, 32'h0000_0000};

        // ---------------- reset / boot ----------------
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        sb.push_back(C_BOOT);
        sb.push_back(C_BOOT + 32'd4);
        sb.push_back(C_BOOT + 32'd8);
        rst      = 1'b0;
        fetch_en = 1'b1;
        first    = -1;
        found    = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (valid) begin
                first = c;
                found = 1'b1;
                chk("boot_first_pc", pc, C_BOOT);
            end
        end
        chk("boot_first_valid_cycle", first, 3);
        wait_sb_empty("boot_consume");
        wait_glog(3, "boot_grants");
        if (glog.size() >= 3) begin
            chk("boot_addr0", glog[0], C_BOOT);
            chk("boot_addr1", glog[1], C_BOOT + 32'd4);
            chk("boot_addr2", glog[2], C_BOOT + 32'd8);
            chk("boot_period01", gcyc[1] - gcyc[0], 3);
            chk("boot_period12", gcyc[2] - gcyc[1], 3);
        end
        wait_quiet();

        // ---------------- table-driven runs ----------------
        for (int r = 0; r < 5; r++) begin
            wait_quiet();
            base    = glog.size();
            gnt_dly = vecs[r].gd;
            rv_dly  = vecs[r].rd;
            rdy_dly = vecs[r].yd;
            for (int k = 0; k < vecs[r].n; k++)
                sb.push_back(vecs[r].start + 32'(4 * k));
            pc_set   = 1'b1;
            target   = vecs[r].start;
            fetch_en = 1'b1;
            tick();
            pc_set = 1'b0;
            wait_sb_empty("vec_consume");
            fetch_en = 1'b0;
            wait_glog(base + vecs[r].n + 1, "vec_next_grant");
            if (glog.size() > base + vecs[r].n) begin
                chk("vec_first_addr", glog[base], vecs[r].start);
                chk("vec_next_addr", glog[base + vecs[r].n], vecs[r].exp_next);
            end
        end
        gnt_dly = 0; rdy_dly = 0;

        // ---------------- redirect while WAIT ----------------
        wait_quiet();
        rv_dly = 2;
        base   = glog.size();
        sb.push_back(32'h0000_0100);
        sb.push_back(32'h0000_0200);
        pc_set   = 1'b1;
        target   = 32'h0000_0100;
        fetch_en = 1'b1;
        tick();
        pc_set = 1'b0;
        wait_glog(base + 2, "wait_redirect_grant");
        pc_set = 1'b1;
        target = 32'h0000_0200;
        tick();
        pc_set = 1'b0;
        wait_sb_empty("wait_redirect_consume");
        fetch_en = 1'b0;
        wait_glog(base + 3, "wait_redirect_next");
        if (glog.size() > base + 2) begin
            chk("wait_stale_addr", glog[base + 1], 32'h0000_0104);
            chk("wait_redirect_addr", glog[base + 2], 32'h0000_0200);
        end
        chk("no_misalign_yet", mis_cnt, 0);
        rv_dly = 0;

        // ---------------- redirect in HOLD with ready, misaligned ----------------
        wait_quiet();
        base = glog.size();
        pc_set   = 1'b1;
        target   = 32'h0000_0400;
        fetch_en = 1'b1;
        tick();
        pc_set = 1'b0;
        sb.push_back(32'h0000_0300);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (valid) found = 1'b1;
            else tick();
        end
        if (!found) timeout("hold_valid");
        chk("hold_presented_pc", pc, 32'h0000_0400);
        pc_set = 1'b1;
        target = 32'h0000_0302;
        tick();
        pc_set = 1'b0;
        chk("misalign_pulse_on", {31'h0, misalign}, 32'h1);
        tick();
        chk("misalign_pulse_off", {31'h0, misalign}, 32'h0);
        wait_sb_empty("hold_redirect_consume");
        fetch_en = 1'b0;
        if (glog.size() > base + 1)
            chk("hold_redirect_addr", glog[base + 1], 32'h0000_0300);
        chk("misalign_count", mis_cnt, 1);

        // ---------------- reset in WAIT, then stray rvalid ----------------
        wait_quiet();
        rv_dly   = 3;
        pc_set   = 1'b1;
        target   = 32'h0000_0500;
        fetch_en = 1'b1;
        tick();
        pc_set = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (pend) found = 1'b1;
        end
        if (!found) timeout("rst_wait_entry");
        rst      = 1'b1;
        fetch_en = 1'b0;
        tick();
        check_reset_vals("midrst");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("stray_rvalid_valid", {31'h0, valid}, 32'h0);
        end
        rv_dly = 0;
        base   = glog.size();
        sb.push_back(C_BOOT);
        fetch_en = 1'b1;
        wait_sb_empty("post_reset_consume");
        fetch_en = 1'b0;
        if (glog.size() > base)
            chk("post_reset_addr", glog[base], C_BOOT);
        else
            timeout("post_reset_grant");

        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
